// File: rtl/kr580_pkg.sv
// Shared types and default constants for the kr580 memory/port controller.
package kr580_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DATA = 2'd2
  } memctl_state_t;

  localparam logic [7:0]  KR580_BANK_PORT = 8'hFE;
  localparam logic [15:0] KR580_WIN_BASE  = 16'hC000;

endpackage

// File: rtl/kr580_memctl_wait.sv
// Wait-state timer: 4-bit loadable down-counter that stops at zero.
// o_done flags the final wait cycle, so the FSM can leave WAIT on that same edge.
module kr580_memctl_wait (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       i_load,
  input  logic [3:0] i_load_val,
  input  logic       i_dec,
  output logic       o_done
);

  logic [3:0] r_cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= 4'd0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != 4'd0)) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  assign o_done = (r_cnt <= 4'd1);

endmodule

// File: rtl/kr580_memctl.sv
// kr580_memctl: wait-state handshake, bank-switched upper window and bank I/O port for the kr580 bus.
// Build option KR580_MEMCTL_ROMPROT_EN: memory writes at or below ROM_TOP never raise mem_we.
module kr580_memctl
  import kr580_pkg::*;
#(
  parameter int          WAIT      = 1,
  parameter int          BANK_W    = 2,
  parameter logic [15:0] WIN_BASE  = KR580_WIN_BASE,
  parameter logic [7:0]  BANK_PORT = KR580_BANK_PORT,
  parameter logic [15:0] ROM_TOP   = 16'h07FF
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [15:0]        address,
  input  logic [7:0]         out,
  input  logic               rd,
  input  logic               we,
  input  logic               pr,
  input  logic               pw,
  output logic [7:0]         in,
  output logic               ready,
  output logic [15+BANK_W:0] mem_address,
  output logic [7:0]         mem_wdata,
  output logic               mem_we,
  input  logic [7:0]         mem_rdata,
  output logic [BANK_W-1:0]  bank
);

  memctl_state_t r_state, w_state_nxt;

  logic [7:0]         r_in;
  logic [7:0]         r_wdata;
  logic               r_ready;
  logic               r_mem_we;
  logic               r_is_wr;
  logic [15+BANK_W:0] r_mem_addr;
  logic [BANK_W-1:0]  r_bank;

  logic               w_take_we, w_take_rd, w_take_pw, w_take_pr, w_take_mem;
  logic               w_cnt_dec, w_wait_last, w_prot, w_is_bank_port;
  logic [15+BANK_W:0] w_phys;

  always_comb begin
    w_phys = {{BANK_W{1'b0}}, address};
    if (address >= WIN_BASE) w_phys = {r_bank, address};
  end

  assign w_is_bank_port = (address[7:0] == BANK_PORT);

`ifdef KR580_MEMCTL_ROMPROT_EN
  assign w_prot = (address <= ROM_TOP);
`else
  localparam logic [15:0] unused_rom_top = ROM_TOP;
  assign w_prot = 1'b0;
`endif

  // The ready cycle is treated as busy so a request still held from the finishing access is not re-taken.
  always_comb begin
    w_state_nxt = r_state;
    w_take_we   = 1'b0;
    w_take_rd   = 1'b0;
    w_take_pw   = 1'b0;
    w_take_pr   = 1'b0;
    w_cnt_dec   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!r_ready) begin
          w_take_we = we;
          w_take_rd = !we && rd;
          w_take_pw = !we && !rd && pw;
          w_take_pr = !we && !rd && !pw && pr;
          if (we || rd) w_state_nxt = (WAIT == 0) ? ST_DATA : ST_WAIT;
        end
      end
      ST_WAIT: begin
        w_cnt_dec = 1'b1;
        if (w_wait_last) w_state_nxt = ST_DATA;
      end
      ST_DATA: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_take_mem = w_take_we | w_take_rd;

  kr580_memctl_wait u_wait (
    .clock      (clock),
    .reset_n    (reset_n),
    .i_load     (w_take_mem),
    .i_load_val (4'(WAIT)),
    .i_dec      (w_cnt_dec),
    .o_done     (w_wait_last)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // The mapped address already carries the bank, so later bank writes cannot disturb an access in flight.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_in       <= 8'h00;
      r_wdata    <= 8'h00;
      r_ready    <= 1'b0;
      r_mem_we   <= 1'b0;
      r_is_wr    <= 1'b0;
      r_mem_addr <= '0;
      r_bank     <= '0;
    end else begin
      r_ready  <= 1'b0;
      r_mem_we <= 1'b0;
      if (w_take_mem) begin
        r_mem_addr <= w_phys;
        r_is_wr    <= w_take_we;
      end
      if (w_take_we) begin
        r_wdata  <= out;
        r_mem_we <= !w_prot;
      end
      if (w_take_pw && w_is_bank_port) r_bank <= out[BANK_W-1:0];
      if (w_take_pr) r_in <= w_is_bank_port ? 8'(r_bank) : 8'hFF;
      if (w_take_pw || w_take_pr) r_ready <= 1'b1;
      if (r_state == ST_DATA) begin
        r_ready <= 1'b1;
        if (!r_is_wr) r_in <= mem_rdata;
      end
    end
  end

  assign in          = r_in;
  assign ready       = r_ready;
  assign mem_address = r_mem_addr;
  assign mem_wdata   = r_wdata;
  assign mem_we      = r_mem_we;
  assign bank        = r_bank;

endmodule
